// File: rtl/pivot_ctrl_if.sv
// Handshake and RAM-control bundle between the pivot sequencer, the pivot
// producer, the two pivot RAM banks and the PE array consumer.
interface pivot_ctrl_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int KW         = 5
) ();
    logic                  ld_valid;
    logic                  ld_ready;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] a_w;
    logic [ADDR_WIDTH-1:0] a_r;
    logic                  cons_ready;
    logic                  rd_sel;
    logic                  out_valid;
    logic                  out_last;
    logic [KW-1:0]         k_idx;

    modport master (
        input  ld_valid, cons_ready,
        output ld_ready, we0, we1, a_w, a_r, rd_sel, out_valid, out_last, k_idx
    );

    modport slave (
        output ld_valid, cons_ready,
        input  ld_ready, we0, we1, a_w, a_r, rd_sel, out_valid, out_last, k_idx
    );
endinterface

// File: rtl/pivot_ctrl.sv
// Ping-pong sequencer for the pivot row buffers: fills one RAM bank from the
// producer while the PE array drains the other, for all B pivot rows of a pass.
module pivot_ctrl #(
    parameter int B          = 32,
    parameter int L          = 4,
    parameter int ADDR_WIDTH = 3,
    parameter int KW         = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    pivot_ctrl_if.master  bus
);

    localparam int                    WORDS     = B / L;
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(WORDS - 1);
    localparam logic [KW:0]           ROWS      = (KW+1)'(B);
    localparam logic [KW:0]           LAST_ROW  = (KW+1)'(B - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                state;
    logic                  wbank;
    logic                  rbank;
    logic [ADDR_WIDTH-1:0] wcnt;
    logic [ADDR_WIDTH-1:0] rcnt;
    logic [KW:0]           rows_loaded;
    logic [KW:0]           rows_read;
    logic [1:0]            full;

    logic ld_ready;
    logic w_fire;
    logic r_fire;
    logic w_last;
    logic r_last;

    assign busy     = (state == S_RUN);
    assign ld_ready = busy && !full[wbank] && (rows_loaded < ROWS);
    assign w_fire   = bus.ld_valid && ld_ready;
    assign r_fire   = busy && full[rbank] && bus.cons_ready;
    assign w_last   = (wcnt == LAST_WORD);
    assign r_last   = (rcnt == LAST_WORD);

    assign bus.ld_ready = ld_ready;
    assign bus.we0      = w_fire && !wbank;
    assign bus.we1      = w_fire && wbank;
    assign bus.a_w      = wcnt;
    assign bus.a_r      = rcnt;

    // Output tags are delayed one cycle so they line up with the registered RAM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            wbank         <= 1'b0;
            rbank         <= 1'b0;
            wcnt          <= '0;
            rcnt          <= '0;
            rows_loaded   <= '0;
            rows_read     <= '0;
            full          <= 2'b00;
            done          <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.rd_sel    <= 1'b0;
            bus.k_idx     <= '0;
        end else begin
            done          <= 1'b0;
            bus.out_valid <= r_fire;
            bus.out_last  <= r_fire && r_last;
            if (r_fire) begin
                bus.rd_sel <= rbank;
                bus.k_idx  <= rows_read[KW-1:0];
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_RUN;
                        wbank       <= 1'b0;
                        rbank       <= 1'b0;
                        wcnt        <= '0;
                        rcnt        <= '0;
                        rows_loaded <= '0;
                        rows_read   <= '0;
                        full        <= 2'b00;
                    end
                end

                S_RUN: begin
                    // Fill and drain always target opposite banks, so both may complete together.
                    if (w_fire) begin
                        if (w_last) begin
                            wcnt        <= '0;
                            full[wbank] <= 1'b1;
                            wbank       <= ~wbank;
                            rows_loaded <= rows_loaded + (KW+1)'(1);
                        end else begin
                            wcnt <= wcnt + ADDR_WIDTH'(1);
                        end
                    end

                    if (r_fire) begin
                        if (r_last) begin
                            rcnt        <= '0;
                            full[rbank] <= 1'b0;
                            rbank       <= ~rbank;
                            rows_read   <= rows_read + (KW+1)'(1);
                            if (rows_read == LAST_ROW) begin
                                state <= S_IDLE;
                                done  <= 1'b1;
                            end
                        end else begin
                            rcnt <= rcnt + ADDR_WIDTH'(1);
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
